// File: rtl/mem_arbiter_if.sv
// Two-port SRAM arbiter bus: requester handshakes plus the asynchronous SRAM pins.
// The slave modport is the arbiter; the master modport is the requesters and the SRAM device.
interface mem_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_done;
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_done;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_dout_en;
  logic [DATA_W-1:0] mem_din;
  logic              mem_ce_n;
  logic              mem_ub_n;
  logic              mem_lb_n;
  logic              mem_oe_n;
  logic              mem_we_n;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_din,
    output p0_gnt, p0_done, p1_gnt, p1_done, rdata, busy,
    output mem_addr, mem_dout, mem_dout_en, mem_ce_n, mem_ub_n, mem_lb_n, mem_oe_n, mem_we_n
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_din,
    input  p0_gnt, p0_done, p1_gnt, p1_done, rdata, busy,
    input  mem_addr, mem_dout, mem_dout_en, mem_ce_n, mem_ub_n, mem_lb_n, mem_oe_n, mem_we_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port asynchronous SRAM arbiter (IDLE/ACCESS/DONE) with WAIT_CYC-cycle strobes.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise P0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input logic          i_clk,
  input logic          i_rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_next_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_port;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_dout_en;
  logic              r_done0;
  logic              r_done1;
  logic              r_busy;

  logic              w_take;
  logic              w_sel_p1;
  logic              w_we_nxt;
  logic              w_ce_n_nxt;
  logic              w_oe_n_nxt;
  logic              w_we_n_nxt;
  logic              w_dout_en_nxt;
  logic              w_done0_nxt;
  logic              w_done1_nxt;
  logic              w_busy_nxt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_rr_ptr;

  // Preferred port for the next tie: the one not granted last
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_take) begin
      r_rr_ptr <= ~w_sel_p1;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  assign w_sel_p1 = bus.p1_req & (~bus.p0_req | r_rr_ptr);
`else
  assign w_sel_p1 = ~bus.p0_req;
`endif

  // Grant is decided in the IDLE cycle itself and is masked while reset is held
  assign w_take      = i_rst_n & (r_state == ST_IDLE) & (bus.p0_req | bus.p1_req);
  assign bus.p0_gnt  = w_take & ~w_sel_p1;
  assign bus.p1_gnt  = w_take & w_sel_p1;
  assign w_we_nxt    = w_take ? (w_sel_p1 ? bus.p1_we : bus.p0_we) : r_we;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_next_state = ST_ACCESS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Strobe values for the coming cycle, registered below so the pins are glitch-free
  always_comb begin
    w_ce_n_nxt    = 1'b1;
    w_oe_n_nxt    = 1'b1;
    w_we_n_nxt    = 1'b1;
    w_dout_en_nxt = 1'b0;
    w_done0_nxt   = 1'b0;
    w_done1_nxt   = 1'b0;
    w_busy_nxt    = 1'b0;
    case (w_next_state)
      ST_ACCESS: begin
        w_ce_n_nxt    = 1'b0;
        w_oe_n_nxt    = w_we_nxt;
        w_we_n_nxt    = ~w_we_nxt;
        w_dout_en_nxt = w_we_nxt;
        w_busy_nxt    = 1'b1;
      end
      ST_DONE: begin
        w_ce_n_nxt    = 1'b0;
        w_dout_en_nxt = r_we;
        w_done0_nxt   = ~r_port;
        w_done1_nxt   = r_port;
        w_busy_nxt    = 1'b1;
      end
      default: begin
        w_ce_n_nxt    = 1'b1;
        w_oe_n_nxt    = 1'b1;
        w_we_n_nxt    = 1'b1;
        w_dout_en_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_dout_en <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ce_n    <= w_ce_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_dout_en <= w_dout_en_nxt;
      r_done0   <= w_done0_nxt;
      r_done1   <= w_done1_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Latch the winning request and run the wait counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_port  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      r_cnt   <= CNT_LOAD;
      r_we    <= w_we_nxt;
      r_port  <= w_sel_p1;
      r_addr  <= w_sel_p1 ? bus.p1_addr : bus.p0_addr;
      r_wdata <= w_sel_p1 ? bus.p1_wdata : bus.p0_wdata;
    end else if ((r_state == ST_ACCESS) && (r_cnt != 4'd0)) begin
      r_cnt   <= r_cnt - 4'd1;
    end else begin
      r_cnt   <= r_cnt;
    end
  end

  // Read data is captured on the last ACCESS cycle so it is valid alongside Done
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if ((r_state == ST_ACCESS) && (r_cnt == 4'd0) && !r_we) begin
      r_rdata <= bus.mem_din;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign bus.p0_done     = r_done0;
  assign bus.p1_done     = r_done1;
  assign bus.rdata       = r_rdata;
  assign bus.busy        = r_busy;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_dout    = r_wdata;
  assign bus.mem_dout_en = r_dout_en;
  assign bus.mem_ce_n    = r_ce_n;
  assign bus.mem_oe_n    = r_oe_n;
  assign bus.mem_we_n    = r_we_n;
  assign bus.mem_ub_n    = 1'b0;
  assign bus.mem_lb_n    = 1'b0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing tests, then random two-port traffic against an
// SRAM model, with a scoreboard fed at grant time and drained by a monitor on Done.
module tb_mem_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int WC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  logic          req  [2];
  logic          we   [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdat [2];

  assign bus.p0_req   = req[0];
  assign bus.p0_we    = we[0];
  assign bus.p0_addr  = addr[0];
  assign bus.p0_wdata = wdat[0];
  assign bus.p1_req   = req[1];
  assign bus.p1_we    = we[1];
  assign bus.p1_addr  = addr[1];
  assign bus.p1_wdata = wdat[1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 257) ^ 16'h5A5A;
  endfunction

  // SRAM device model: 64 words at address bits [9:4]
  logic [DW-1:0] sram [0:63];
  logic          bd_en = 1'b0;
  logic [5:0]    bd_idx = 6'd0;
  logic [DW-1:0] bd_val = 16'h0000;

  assign bus.mem_din = (!bus.mem_ce_n && !bus.mem_oe_n) ? sram[bus.mem_addr[9:4]] : 16'h0000;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) sram[i] <= init_val(i);
    end else if (bd_en) begin
      sram[bd_idx] <= bd_val;
    end else if (!bus.mem_ce_n && !bus.mem_we_n) begin
      sram[bus.mem_addr[9:4]] <= bus.mem_dout;
    end
  end

  // Reference model: memory contents in grant order plus expected arbitration
  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            due;
  } exp_t;

  exp_t          q [$];
  exp_t          e;
  logic [DW-1:0] ref_mem [0:63];
  int            cyc = 0;
  int            oe_cnt, we_cnt, en_cnt, win;
  bit            prot_ok;
  bit            exp_ptr;
  bit            gseen [2];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      gseen[0] = bus.p0_gnt;
      gseen[1] = bus.p1_gnt;
      if (!rst_n) begin
        q.delete();
        exp_ptr = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
      end else begin
        if (bd_en) ref_mem[bd_idx] = bd_val;
        if (bus.busy) begin
          if (!bus.mem_oe_n) oe_cnt++;
          if (!bus.mem_we_n) we_cnt++;
          if (bus.mem_dout_en) en_cnt++;
          if (bus.mem_ce_n || (!bus.mem_oe_n && !bus.mem_we_n)) prot_ok = 1'b0;
          if (q.size() > 0) begin
            if (bus.mem_addr !== q[0].addr) prot_ok = 1'b0;
            if (q[0].we && (bus.mem_dout !== q[0].wdata)) prot_ok = 1'b0;
          end
        end else if (!bus.mem_ce_n || !bus.mem_oe_n || !bus.mem_we_n || bus.mem_dout_en) begin
          prot_ok = 1'b0;
        end
        if (bus.p0_done || bus.p1_done) begin
          chk("done_onehot", longint'(bus.p0_done & bus.p1_done), 0);
          if (q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("done_port", bus.p1_done ? 1 : 0, e.port);
            chk("latency", cyc, e.due);
            chk("oe_cycles", oe_cnt, e.we ? 0 : WC);
            chk("we_cycles", we_cnt, e.we ? WC : 0);
            chk("dout_en_cycles", en_cnt, e.we ? WC + 1 : 0);
            chk("strobes_addr_stable", longint'(prot_ok), 1);
            if (!e.we) chk("rdata", bus.rdata, e.rdata);
          end
        end
        if (!bus.busy && (req[0] || req[1])) begin
          if (req[0] && req[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win = int'(exp_ptr);
`else
            win = 0;
`endif
          end else begin
            win = req[0] ? 0 : 1;
          end
          chk("grant_p0", longint'(bus.p0_gnt), (win == 0) ? 1 : 0);
          chk("grant_p1", longint'(bus.p1_gnt), (win == 1) ? 1 : 0);
          exp_ptr     = (win == 0);
          e.port      = win;
          e.we        = we[win];
          e.addr      = addr[win];
          e.wdata     = wdat[win];
          e.rdata     = ref_mem[addr[win][9:4]];
          e.due       = cyc + WC + 1;
          if (we[win]) ref_mem[addr[win][9:4]] = wdat[win];
          q.push_back(e);
          oe_cnt  = 0;
          we_cnt  = 0;
          en_cnt  = 0;
          prot_ok = 1'b1;
        end else if (bus.p0_gnt || bus.p1_gnt) begin
          chk("spurious_gnt", 1, 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int p);
    req[p]  = 1'b1;
    we[p]   = 1'($urandom_range(0, 1));
    addr[p] = AW'($urandom_range(0, 63) * 16);
    wdat[p] = DW'($urandom);
  endtask

  int exp_seq [3];
  int w;

  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdat[p] = '0;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0};
`else
    exp_seq = '{0, 0, 0};
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", longint'(bus.mem_ce_n), 1);
    chk("rst_oe_n", longint'(bus.mem_oe_n), 1);
    chk("rst_we_n", longint'(bus.mem_we_n), 1);
    chk("rst_dout_en", longint'(bus.mem_dout_en), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_dout", bus.mem_dout, 0);
    chk("rst_gnt_done", longint'({bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done}), 0);
    chk("ub_lb", longint'({bus.mem_ub_n, bus.mem_lb_n}), 0);
    rst_n = 1'b1;
    step();

    // P0 read of 0x00010 returning 0xBEEF
    bd_idx = 6'd1; bd_val = 16'hBEEF; bd_en = 1'b1;
    step();
    bd_en = 1'b0;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 20'h00010;
    @(negedge clk); chk("rd_gnt_t", longint'(bus.p0_gnt), 1);
    step(); req[0] = 1'b0;
    @(negedge clk); chk("rd_oe_t1", longint'(bus.mem_oe_n), 0);
    step();
    @(negedge clk); chk("rd_oe_t2", longint'(bus.mem_oe_n), 0);
    step();
    @(negedge clk);
    chk("rd_done_t3", longint'(bus.p0_done), 1);
    chk("rd_rdata_t3", bus.rdata, 16'hBEEF);
    chk("rd_oe_t3", longint'(bus.mem_oe_n), 1);
    step();

    // P1 write of 0x1234 to 0x00200
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 20'h00200; wdat[1] = 16'h1234;
    @(negedge clk); chk("wr_gnt_t", longint'(bus.p1_gnt), 1);
    step(); req[1] = 1'b0;
    @(negedge clk); chk("wr_we_t1", longint'(bus.mem_we_n), 0);
    step();
    @(negedge clk); chk("wr_we_t2", longint'(bus.mem_we_n), 0);
    step();
    @(negedge clk);
    chk("wr_we_done", longint'(bus.mem_we_n), 1);
    chk("wr_dout_en_done", longint'(bus.mem_dout_en), 1);
    chk("wr_dout_done", bus.mem_dout, 16'h1234);
    chk("wr_done_t3", longint'(bus.p1_done), 1);
    step();

    // Both ports held high for three accesses, starting from a fresh reset
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 20'h00050;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 20'h00060;
    for (int k = 0; k < 3; k++) begin
      w = -1;
      for (int c = 0; c < 20 && w < 0; c++) begin
        @(negedge clk);
        if (bus.p0_gnt) w = 0;
        else if (bus.p1_gnt) w = 1;
      end
      chk("tie_winner", w, exp_seq[k]);
    end
    step(); req[0] = 1'b0; req[1] = 1'b0;
    repeat (6) step();

    // P0 re-requests in the DONE cycle: next grant four cycles later
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 20'h00030;
    @(negedge clk); chk("rr_gnt_t", longint'(bus.p0_gnt), 1);
    step(); req[0] = 1'b0;
    step();
    step(); req[0] = 1'b1; addr[0] = 20'h00070;
    @(negedge clk); chk("rr_done_t3", longint'(bus.p0_done), 1);
    step();
    @(negedge clk); chk("rr_gnt_t4", longint'(bus.p0_gnt), 1);
    step(); req[0] = 1'b0;
    repeat (6) step();

    // Reset during the second ACCESS cycle of a write
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 20'h00400; wdat[1] = 16'hCAFE;
    @(negedge clk); chk("abort_gnt", longint'(bus.p1_gnt), 1);
    step(); req[1] = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_n", longint'(bus.mem_we_n), 1);
    chk("abort_dout_en", longint'(bus.mem_dout_en), 0);
    chk("abort_busy", longint'(bus.busy), 0);
    chk("abort_done", longint'(bus.p1_done), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("abort_queue_empty", q.size(), 0);

    // Random traffic on both ports
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (req[p] && gseen[p]) begin
          if ($urandom_range(0, 1) == 1) new_req(p);
          else req[p] = 1'b0;
        end else if (!req[p] && ($urandom_range(0, 3) == 0)) begin
          new_req(p);
        end
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (10) step();
    chk("drain_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
